// File: rtl/upsample_ub_pkg.sv
// Shared types and helpers for the nearest-neighbour upsampling row buffer.
// Also defines the pixel-type macro used by the buffer top level.
package upsample_ub_pkg;

  typedef logic bank_sel_t;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`ifndef UPSAMPLE_UB_PIX_T
`define UPSAMPLE_UB_PIX_T(dw, nch) logic [(dw)*(nch)-1:0]
`endif

// File: rtl/upsample_ub_row_bank.sv
// One row of pixel storage: synchronous write port, asynchronous read port.
// Contents are not reset; the owner tracks validity with its full bit.
module upsample_ub_row_bank #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int W     = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/upsample_rowbuf_ub.sv
// Nearest-neighbour upsampling buffer with two ping-pong row banks.
// Define UPSAMPLE_UB_FRAME_LAST_EN to add row counters and the out_last port.
module upsample_rowbuf_ub
  import upsample_ub_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NCH    = 1,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int UP_X   = 2,
  parameter int UP_Y   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W*NCH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W*NCH-1:0] out_data
`ifdef UPSAMPLE_UB_FRAME_LAST_EN
  ,
  output logic                  out_last
`endif
);

  // Valid/ready on both sides: a pixel transfers on a rising edge where valid
  // and ready are both high; neither ready depends on the matching valid.

  localparam int PW  = DATA_W * NCH;
  localparam int CW  = clog2_min1(IMG_W);
  localparam int SXW = clog2_min1(UP_X);
  localparam int SYW = clog2_min1(UP_Y);

  localparam logic [CW-1:0]  COL_LAST = CW'(IMG_W - 1);
  localparam logic [SXW-1:0] SX_LAST  = SXW'(UP_X - 1);
  localparam logic [SYW-1:0] SY_LAST  = SYW'(UP_Y - 1);

  typedef `UPSAMPLE_UB_PIX_T(DATA_W, NCH) pix_t;

  logic [1:0]     full, full_nxt;
  bank_sel_t      wr_sel, rd_sel;
  logic [CW-1:0]  wr_col, rd_col;
  logic [SXW-1:0] sx;
  logic [SYW-1:0] sy;
  logic           in_fire, out_fire;
  logic           wr_row_end, sx_end, col_end, sy_end, rd_row_end;
  pix_t           rdata0, rdata1;

  assign in_ready   = !full[wr_sel];
  assign out_valid  = full[rd_sel];
  assign in_fire    = in_valid & in_ready;
  assign out_fire   = out_valid & out_ready;
  assign wr_row_end = (wr_col == COL_LAST);
  assign sx_end     = (sx == SX_LAST);
  assign col_end    = (rd_col == COL_LAST);
  assign sy_end     = (sy == SY_LAST);
  assign rd_row_end = sx_end & col_end & sy_end;

  upsample_ub_row_bank #(.DEPTH(IMG_W), .AW(CW), .W(PW)) u_bank0 (
    .clk   (clk),
    .we    (in_fire & (wr_sel == 1'b0)),
    .waddr (wr_col),
    .wdata (in_data),
    .raddr (rd_col),
    .rdata (rdata0)
  );

  upsample_ub_row_bank #(.DEPTH(IMG_W), .AW(CW), .W(PW)) u_bank1 (
    .clk   (clk),
    .we    (in_fire & (wr_sel == 1'b1)),
    .waddr (wr_col),
    .wdata (in_data),
    .raddr (rd_col),
    .rdata (rdata1)
  );

  assign out_data = rd_sel ? rdata1 : rdata0;

  // Writer and reader always own different banks, so both updates can apply.
  always_comb begin
    full_nxt = full;
    if (in_fire && wr_row_end) full_nxt[wr_sel] = 1'b1;
    if (out_fire && rd_row_end) full_nxt[rd_sel] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full   <= 2'b00;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      wr_col <= '0;
      rd_col <= '0;
      sx     <= '0;
      sy     <= '0;
    end else if (flush) begin
      full   <= 2'b00;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      wr_col <= '0;
      rd_col <= '0;
      sx     <= '0;
      sy     <= '0;
    end else begin
      full <= full_nxt;
      if (in_fire) begin
        if (wr_row_end) begin
          wr_col <= '0;
          wr_sel <= ~wr_sel;
        end else begin
          wr_col <= wr_col + 1'b1;
        end
      end
      // Repeat nest, innermost first: pixel repeat, column, row repeat.
      if (out_fire) begin
        if (sx_end) begin
          sx <= '0;
          if (col_end) begin
            rd_col <= '0;
            if (sy_end) begin
              sy     <= '0;
              rd_sel <= ~rd_sel;
            end else begin
              sy <= sy + 1'b1;
            end
          end else begin
            rd_col <= rd_col + 1'b1;
          end
        end else begin
          sx <= sx + 1'b1;
        end
      end
    end
  end

`ifdef UPSAMPLE_UB_FRAME_LAST_EN
  localparam int RW = clog2_min1(IMG_H);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [RW-1:0] wr_row, rd_row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_row <= '0;
      rd_row <= '0;
    end else if (flush) begin
      wr_row <= '0;
      rd_row <= '0;
    end else begin
      if (in_fire && wr_row_end) wr_row <= (wr_row == ROW_LAST) ? '0 : wr_row + 1'b1;
      if (out_fire && rd_row_end) rd_row <= (rd_row == ROW_LAST) ? '0 : rd_row + 1'b1;
    end
  end

  assign out_last = out_valid & (rd_row == ROW_LAST) & rd_row_end;
`endif

endmodule

// File: tb/tb_upsample_rowbuf_ub.sv
// Bench for upsample_rowbuf_ub: directed scenarios plus random traffic against
// a row-level reference model. Covers out_last when UPSAMPLE_UB_FRAME_LAST_EN is set.
module tb_upsample_rowbuf_ub;

  localparam int W         = 4;
  localparam int H         = 2;
  localparam int UX        = 2;
  localparam int UY        = 2;
  localparam int ROW_OUT   = W * UX * UY;
  localparam int FRAME_OUT = ROW_OUT * H;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_last;

  logic        p_flush = 1'b0;
  logic        p_in_valid = 1'b0;
  logic        p_in_ready;
  logic [15:0] p_in_data = '0;
  logic        p_out_valid;
  logic        p_out_ready = 1'b1;
  logic [15:0] p_out_data;
  logic        p_out_last;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  upsample_rowbuf_ub #(.DATA_W(16), .NCH(1), .IMG_W(W), .IMG_H(H), .UP_X(UX), .UP_Y(UY)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef UPSAMPLE_UB_FRAME_LAST_EN
    ,
    .out_last  (out_last)
`endif
  );

  upsample_rowbuf_ub #(.DATA_W(16), .NCH(1), .IMG_W(W), .IMG_H(H), .UP_X(1), .UP_Y(1)) dut_pass (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (p_flush),
    .in_valid  (p_in_valid),
    .in_ready  (p_in_ready),
    .in_data   (p_in_data),
    .out_valid (p_out_valid),
    .out_ready (p_out_ready),
    .out_data  (p_out_data)
`ifdef UPSAMPLE_UB_FRAME_LAST_EN
    ,
    .out_last  (p_out_last)
`endif
  );

`ifndef UPSAMPLE_UB_FRAME_LAST_EN
  assign out_last   = 1'b0;
  assign p_out_last = 1'b0;
`endif

  // Reference model: completed rows expand into exp_q; a row counts as
  // pending until all ROW_OUT of its outputs have been consumed.
  logic [15:0] exp_q[$];
  logic [15:0] cur_row[$];
  logic [15:0] got_q[$];
  logic        got_last_q[$];
  int          rows_pending = 0;
  int          out_cnt = 0;
  int          frame_idx = 0;
  logic        s_in_f = 1'b0;
  logic        s_out_f = 1'b0;
  logic [15:0] s_in_d = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      cur_row.delete();
      rows_pending = 0;
      out_cnt = 0;
      frame_idx = 0;
    end
    checks++;
    if (in_ready !== (rows_pending < 2)) begin
      errors++;
      $display("FAIL sb_in_ready: got %b expected %b (t=%0t)", in_ready, rows_pending < 2, $time);
    end
    checks++;
    if (out_valid !== (rows_pending > 0)) begin
      errors++;
      $display("FAIL sb_out_valid: got %b expected %b (t=%0t)", out_valid, rows_pending > 0, $time);
    end
    if (out_valid === 1'b1 && exp_q.size() > 0) begin
      checks++;
      if (out_data !== exp_q[0]) begin
        errors++;
        $display("FAIL sb_out_data: got %h expected %h (t=%0t)", out_data, exp_q[0], $time);
      end
    end
`ifdef UPSAMPLE_UB_FRAME_LAST_EN
    checks++;
    if (out_last !== ((rows_pending > 0) && (frame_idx == FRAME_OUT - 1))) begin
      errors++;
      $display("FAIL sb_out_last: got %b at output index %0d (t=%0t)", out_last, frame_idx, $time);
    end
`endif
    s_in_f  = in_valid && (rows_pending < 2);
    s_in_d  = in_data;
    s_out_f = (rows_pending > 0) && out_ready;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      got_q.push_back(out_data);
      got_last_q.push_back(out_last);
    end
  end

  always @(posedge clk) begin
    if (!rst_n || flush) begin
      exp_q.delete();
      cur_row.delete();
      rows_pending = 0;
      out_cnt = 0;
      frame_idx = 0;
    end else begin
      if (s_out_f) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        out_cnt++;
        if (out_cnt == ROW_OUT) begin
          out_cnt = 0;
          rows_pending--;
        end
        frame_idx = (frame_idx + 1) % FRAME_OUT;
      end
      if (s_in_f) begin
        cur_row.push_back(s_in_d);
        if (cur_row.size() == W) begin
          for (int y = 0; y < UY; y++)
            for (int c = 0; c < W; c++)
              for (int x = 0; x < UX; x++)
                exp_q.push_back(cur_row[c]);
          rows_pending++;
          cur_row.delete();
        end
      end
    end
  end

  task automatic send_pixel(input logic [15:0] d);
    int   budget;
    logic acc;
    budget   = 0;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    while (!acc && budget < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    in_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout: pixel %h not accepted in %0d cycles", d, budget);
    end
  endtask

  task automatic wait_outputs(input int n);
    int budget;
    budget = 0;
    while (got_q.size() < n && budget < 2000) begin
      @(posedge clk);
      #1;
      budget++;
    end
    checks++;
    if (got_q.size() < n) begin
      errors++;
      $display("FAIL wait_outputs: got %0d outputs expected %0d", got_q.size(), n);
    end
  endtask

  task automatic do_flush();
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'hdead;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    got_q.delete();
    got_last_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [15:0] e;
    do_flush();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) send_pixel(16'(i));
    wait_outputs(32);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (got_q.size() != 32) begin
      errors++;
      $display("FAIL basic_count: got %0d outputs expected 32", got_q.size());
    end
    for (int i = 0; i < 32 && i < got_q.size(); i++) begin
      e = 16'((i / 16) * 4 + ((i % 8) / 2) + 1);
      checks++;
      if (got_q[i] !== e) begin
        errors++;
        $display("FAIL basic_data[%0d]: got %h expected %h", i, got_q[i], e);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] e;
    do_flush();
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send_pixel(16'(i));
    in_valid = 1'b1;
    in_data  = 16'd9;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_in_ready: got %b expected 0 with two rows buffered", in_ready);
      end
      checks++;
      if (out_data !== 16'd1) begin
        errors++;
        $display("FAIL bp_hold_data: got %h expected 0001 while stalled", out_data);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    for (int i = 9; i <= 12; i++) send_pixel(16'(i));
    wait_outputs(48);
    for (int i = 0; i < 48 && i < got_q.size(); i++) begin
      e = 16'((i / 16) * 4 + ((i % 8) / 2) + 1);
      checks++;
      if (got_q[i] !== e) begin
        errors++;
        $display("FAIL bp_data[%0d]: got %h expected %h", i, got_q[i], e);
      end
    end
  endtask

  task automatic test_simultaneous();
    int          budget;
    logic [15:0] e;
    do_flush();
    out_ready = 1'b0;
    for (int i = 1; i <= 7; i++) send_pixel(16'(i));
    out_ready = 1'b1;
    budget = 0;
    while (got_q.size() < 15 && budget < 200) begin
      @(posedge clk);
      #1;
      budget++;
    end
    send_pixel(16'd8);
    checks++;
    if (got_q.size() != 16) begin
      errors++;
      $display("FAIL sim_align: got %0d outputs at row completion expected 16", got_q.size());
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL sim_in_ready: got %b expected 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL sim_out_valid: got %b expected 1", out_valid);
    end
    @(posedge clk);
    #1;
    for (int i = 9; i <= 12; i++) send_pixel(16'(i));
    wait_outputs(48);
    for (int i = 0; i < 48 && i < got_q.size(); i++) begin
      e = 16'((i / 16) * 4 + ((i % 8) / 2) + 1);
      checks++;
      if (got_q[i] !== e) begin
        errors++;
        $display("FAIL sim_data[%0d]: got %h expected %h", i, got_q[i], e);
      end
    end
  endtask

  task automatic test_reset_midrow();
    logic [15:0] e;
    do_flush();
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send_pixel(16'(i));
    out_ready = 1'b1;
    send_pixel(16'd5);
    out_ready = 1'b0;
    send_pixel(16'd6);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_in_ready: got %b expected 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_out_valid: got %b expected 0", out_valid);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    got_q.delete();
    got_last_q.delete();
    out_ready = 1'b1;
    for (int i = 9; i <= 12; i++) send_pixel(16'(i));
    wait_outputs(16);
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      e = 16'(9 + (i % 8) / 2);
      checks++;
      if (got_q[i] !== e) begin
        errors++;
        $display("FAIL midrst_data[%0d]: got %h expected %h", i, got_q[i], e);
      end
    end
  endtask

  task automatic test_random();
    int budget;
    do_flush();
    repeat (400) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    budget = 0;
    while (rows_pending > 0 && budget < 200) begin
      @(posedge clk);
      #1;
      budget++;
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rand_drain: out_valid %b expected 0 after drain", out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_passthrough();
    logic [15:0] sent[$];
    logic [15:0] pgot[$];
    int          first_out;
    first_out = -1;
    for (int c = 0; c < 24; c++) begin
      p_in_valid = (c < 8);
      p_in_data  = 16'(16'h100 + c);
      @(negedge clk);
      if (p_in_valid && p_in_ready) sent.push_back(p_in_data);
      if (p_out_valid) begin
        pgot.push_back(p_out_data);
        if (first_out < 0) first_out = c;
      end
      @(posedge clk);
      #1;
    end
    p_in_valid = 1'b0;
    checks++;
    if (sent.size() != 8) begin
      errors++;
      $display("FAIL pass_accept: accepted %0d pixels expected 8", sent.size());
    end
    checks++;
    if (pgot.size() != 8) begin
      errors++;
      $display("FAIL pass_count: got %0d outputs expected 8", pgot.size());
    end
    checks++;
    if (first_out != W) begin
      errors++;
      $display("FAIL pass_latency: first output at cycle %0d expected %0d", first_out, W);
    end
    for (int i = 0; i < 8 && i < pgot.size(); i++) begin
      checks++;
      if (pgot[i] !== 16'(16'h100 + i)) begin
        errors++;
        $display("FAIL pass_data[%0d]: got %h expected %h", i, pgot[i], 16'(16'h100 + i));
      end
    end
  endtask

`ifdef UPSAMPLE_UB_FRAME_LAST_EN
  task automatic test_frame_last();
    do_flush();
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) send_pixel(16'(i));
    wait_outputs(64);
    for (int i = 0; i < 64 && i < got_last_q.size(); i++) begin
      checks++;
      if (got_last_q[i] !== ((i == 31) || (i == 63))) begin
        errors++;
        $display("FAIL frame_last[%0d]: got %b", i, got_last_q[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_simultaneous();
    test_reset_midrow();
    test_random();
    test_passthrough();
`ifdef UPSAMPLE_UB_FRAME_LAST_EN
    test_frame_last();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
